// File: rtl/redirect_ctrl.sv
// Redirect sequencer between EXU (branch/trap) and IFU: flush, drain in-flight fetches, then hand the target PC to the IFU.
// Optional statistics counters are enabled with `define REDIRECT_STATS_EN.
module redirect_ctrl #(
    parameter int PC_W            = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bju_vld,
    input  logic            bju_taken,
    input  logic [PC_W-1:0] bju_pc,
    input  logic            trap_vld,
    input  logic [PC_W-1:0] trap_pc,
    input  logic            ifu_req_fire,
    input  logic            ifu_rsp_fire,
    input  logic            ifu_redirect_rdy,
    output logic            ifu_redirect_vld,
    output logic [PC_W-1:0] ifu_redirect_pc,
    output logic            flush,
    output logic            fetch_stall,
    output logic            discard_rsp,
    output logic            busy
`ifdef REDIRECT_STATS_EN
   ,output logic [31:0]     stat_redirects,
    output logic [31:0]     stat_drain_cycles,
    output logic [31:0]     stat_trap_overrides
`endif
);

    // state    | meaning
    // IDLE     | no redirect pending, fetch runs freely
    // DRAIN    | redirect accepted, waiting for in-flight responses (dropped)
    // REDIRECT | target PC offered to IFU until ifu_redirect_rdy
    typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [PC_W-1:0]   pc_q;
    logic              accept;

    always_comb begin
        cnt_next = cnt;
        if (ifu_req_fire && !ifu_rsp_fire) begin
            if (cnt != CNT_MAX) cnt_next = cnt + CNT_W'(1);
        end else if (ifu_rsp_fire && !ifu_req_fire) begin
            if (cnt != '0) cnt_next = cnt - CNT_W'(1);
        end
    end

    assign accept = trap_vld || (bju_vld && bju_taken);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pc_q  <= '0;
            flush <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            flush <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        pc_q  <= trap_vld ? trap_pc : bju_pc;
                        flush <= 1'b1;
                        state <= (cnt_next != '0) ? DRAIN : REDIRECT;
                    end
                end
                DRAIN: begin
                    // branch results here are wrong-path; only a trap may retarget
                    if (trap_vld) begin
                        pc_q  <= trap_pc;
                        flush <= 1'b1;
                    end
                    if (cnt_next == '0) state <= REDIRECT;
                end
                REDIRECT: begin
                    // a trap coinciding with rdy lets the old PC go and re-offers the trap PC
                    if (trap_vld) begin
                        pc_q  <= trap_pc;
                        flush <= 1'b1;
                    end else if (ifu_redirect_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy             = (state != IDLE);
    assign fetch_stall      = (state != IDLE) || (cnt == CNT_MAX);
    assign discard_rsp      = (state == DRAIN);
    assign ifu_redirect_vld = (state == REDIRECT);
    assign ifu_redirect_pc  = (state == REDIRECT) ? pc_q : '0;

`ifdef REDIRECT_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_redirects      <= '0;
            stat_drain_cycles   <= '0;
            stat_trap_overrides <= '0;
        end else begin
            if (state == REDIRECT && ifu_redirect_rdy) stat_redirects <= stat_redirects + 32'd1;
            if (state == DRAIN) stat_drain_cycles <= stat_drain_cycles + 32'd1;
            if (trap_vld && state != IDLE) stat_trap_overrides <= stat_trap_overrides + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(ifu_rsp_fire && cnt == '0))
                else $error("fetch response with no outstanding request");
            assert (!(ifu_req_fire && fetch_stall))
                else $error("fetch request issued while stalled");
        end
    end
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed self-checking bench for redirect_ctrl.
module tb_redirect_ctrl;
    localparam int PC_W = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            bju_vld, bju_taken, trap_vld;
    logic [PC_W-1:0] bju_pc, trap_pc;
    logic            ifu_req_fire, ifu_rsp_fire, ifu_redirect_rdy;
    logic            ifu_redirect_vld, flush, fetch_stall, discard_rsp, busy;
    logic [PC_W-1:0] ifu_redirect_pc;
`ifdef REDIRECT_STATS_EN
    logic [31:0]     stat_redirects, stat_drain_cycles, stat_trap_overrides;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    redirect_ctrl #(.PC_W(PC_W), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .bju_vld(bju_vld), .bju_taken(bju_taken), .bju_pc(bju_pc),
        .trap_vld(trap_vld), .trap_pc(trap_pc),
        .ifu_req_fire(ifu_req_fire), .ifu_rsp_fire(ifu_rsp_fire),
        .ifu_redirect_rdy(ifu_redirect_rdy),
        .ifu_redirect_vld(ifu_redirect_vld), .ifu_redirect_pc(ifu_redirect_pc),
        .flush(flush), .fetch_stall(fetch_stall), .discard_rsp(discard_rsp), .busy(busy)
`ifdef REDIRECT_STATS_EN
       ,.stat_redirects(stat_redirects), .stat_drain_cycles(stat_drain_cycles),
        .stat_trap_overrides(stat_trap_overrides)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bju_vld = 0; bju_taken = 0; bju_pc = '0;
        trap_vld = 0; trap_pc = '0;
        ifu_req_fire = 0; ifu_rsp_fire = 0; ifu_redirect_rdy = 0;
    endtask

    task automatic take_branch(input logic [PC_W-1:0] pc);
        bju_vld = 1; bju_taken = 1; bju_pc = pc;
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        rst_n = 0; clear_inputs();
        step(); step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b exp 0", busy); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %0b exp 0", flush); end
        n_checks++; if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b exp 0", fetch_stall); end
        n_checks++; if (discard_rsp !== 1'b0) begin n_fail++; $display("FAIL reset_discard got %0b exp 0", discard_rsp); end
        n_checks++; if (ifu_redirect_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %0b exp 0", ifu_redirect_vld); end
        n_checks++; if (ifu_redirect_pc !== 64'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", ifu_redirect_pc); end
        rst_n = 1;
        step();
    endtask

    task automatic test_taken_direct();
        take_branch(64'h8000_0100);
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL direct_flush got %0b exp 1", flush); end
        n_checks++; if (ifu_redirect_vld !== 1'b1) begin n_fail++; $display("FAIL direct_vld got %0b exp 1", ifu_redirect_vld); end
        n_checks++; if (ifu_redirect_pc !== 64'h8000_0100) begin n_fail++; $display("FAIL direct_pc got %h exp 80000100", ifu_redirect_pc); end
        n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL direct_stall got %0b exp 1", fetch_stall); end
        ifu_redirect_rdy = 1;
        step();
        clear_inputs();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL direct_idle got %0b exp 0", busy); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL direct_flush_off got %0b exp 0", flush); end
        n_checks++; if (ifu_redirect_vld !== 1'b0) begin n_fail++; $display("FAIL direct_vld_off got %0b exp 0", ifu_redirect_vld); end
    endtask

    task automatic test_not_taken();
        bju_vld = 1; bju_taken = 0; bju_pc = 64'h8000_0900;
        step();
        clear_inputs();
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL nt_flush got %0b exp 0", flush); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nt_busy got %0b exp 0", busy); end
        n_checks++; if (ifu_redirect_vld !== 1'b0) begin n_fail++; $display("FAIL nt_vld got %0b exp 0", ifu_redirect_vld); end
    endtask

    task automatic test_drain();
        ifu_req_fire = 1; step(); step(); ifu_req_fire = 0;
        n_checks++; if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL drain_prestall got %0b exp 0", fetch_stall); end
        take_branch(64'h8000_0200);
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL drain_flush got %0b exp 1", flush); end
        n_checks++; if (discard_rsp !== 1'b1) begin n_fail++; $display("FAIL drain_discard got %0b exp 1", discard_rsp); end
        n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL drain_stall got %0b exp 1", fetch_stall); end
        n_checks++; if (ifu_redirect_vld !== 1'b0) begin n_fail++; $display("FAIL drain_vld_early got %0b exp 0", ifu_redirect_vld); end
        ifu_rsp_fire = 1; step();
        n_checks++; if (discard_rsp !== 1'b1) begin n_fail++; $display("FAIL drain_discard2 got %0b exp 1", discard_rsp); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL drain_flush_once got %0b exp 0", flush); end
        step(); ifu_rsp_fire = 0;
        n_checks++; if (ifu_redirect_vld !== 1'b1) begin n_fail++; $display("FAIL drain_vld got %0b exp 1", ifu_redirect_vld); end
        n_checks++; if (discard_rsp !== 1'b0) begin n_fail++; $display("FAIL drain_discard_off got %0b exp 0", discard_rsp); end
        n_checks++; if (ifu_redirect_pc !== 64'h8000_0200) begin n_fail++; $display("FAIL drain_pc got %h exp 80000200", ifu_redirect_pc); end
        ifu_redirect_rdy = 1; step(); clear_inputs();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_idle got %0b exp 0", busy); end
    endtask

    task automatic test_simultaneous();
        trap_vld = 1; trap_pc = 64'h8000_0004;
        bju_vld = 1; bju_taken = 1; bju_pc = 64'h8000_0300;
        step(); clear_inputs();
        n_checks++; if (ifu_redirect_pc !== 64'h8000_0004) begin n_fail++; $display("FAIL simul_pc got %h exp 80000004", ifu_redirect_pc); end
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL simul_flush got %0b exp 1", flush); end
        step();
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL simul_single got %0b exp 0", flush); end
        n_checks++; if (ifu_redirect_pc !== 64'h8000_0004) begin n_fail++; $display("FAIL simul_hold got %h exp 80000004", ifu_redirect_pc); end
        ifu_redirect_rdy = 1; step(); clear_inputs();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_idle got %0b exp 0", busy); end
    endtask

    task automatic test_trap_override();
        take_branch(64'h8000_0400);
        step();
        n_checks++; if (ifu_redirect_pc !== 64'h8000_0400) begin n_fail++; $display("FAIL ovr_hold got %h exp 80000400", ifu_redirect_pc); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL ovr_noflush got %0b exp 0", flush); end
        // wrong-path branch result must not retarget
        bju_vld = 1; bju_taken = 1; bju_pc = 64'h8000_0A00; step(); clear_inputs();
        n_checks++; if (ifu_redirect_pc !== 64'h8000_0400) begin n_fail++; $display("FAIL ovr_bju_ignored got %h exp 80000400", ifu_redirect_pc); end
        trap_vld = 1; trap_pc = 64'h8000_0004; step(); clear_inputs();
        n_checks++; if (ifu_redirect_pc !== 64'h8000_0004) begin n_fail++; $display("FAIL ovr_pc got %h exp 80000004", ifu_redirect_pc); end
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL ovr_flush got %0b exp 1", flush); end
        n_checks++; if (ifu_redirect_vld !== 1'b1) begin n_fail++; $display("FAIL ovr_vld got %0b exp 1", ifu_redirect_vld); end
        ifu_redirect_rdy = 1; step(); clear_inputs();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_idle got %0b exp 0", busy); end
    endtask

    task automatic test_trap_with_rdy();
        take_branch(64'h8000_0500);
        trap_vld = 1; trap_pc = 64'h8000_0008; ifu_redirect_rdy = 1;
        step(); clear_inputs();
        n_checks++; if (ifu_redirect_vld !== 1'b1) begin n_fail++; $display("FAIL trdy_vld got %0b exp 1", ifu_redirect_vld); end
        n_checks++; if (ifu_redirect_pc !== 64'h8000_0008) begin n_fail++; $display("FAIL trdy_pc got %h exp 80000008", ifu_redirect_pc); end
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL trdy_flush got %0b exp 1", flush); end
        ifu_redirect_rdy = 1; step(); clear_inputs();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL trdy_idle got %0b exp 0", busy); end
    endtask

    task automatic test_trap_in_drain();
        ifu_req_fire = 1; step(); ifu_req_fire = 0;
        take_branch(64'h8000_0600);
        trap_vld = 1; trap_pc = 64'h8000_000C; step(); clear_inputs();
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL tdrain_flush got %0b exp 1", flush); end
        n_checks++; if (discard_rsp !== 1'b1) begin n_fail++; $display("FAIL tdrain_discard got %0b exp 1", discard_rsp); end
        ifu_rsp_fire = 1; step(); clear_inputs();
        n_checks++; if (ifu_redirect_vld !== 1'b1) begin n_fail++; $display("FAIL tdrain_vld got %0b exp 1", ifu_redirect_vld); end
        n_checks++; if (ifu_redirect_pc !== 64'h8000_000C) begin n_fail++; $display("FAIL tdrain_pc got %h exp 8000000c", ifu_redirect_pc); end
        ifu_redirect_rdy = 1; step(); clear_inputs();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tdrain_idle got %0b exp 0", busy); end
    endtask

    task automatic test_saturate_stall();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL sat_stall_pre%0d got %0b exp 0", i, fetch_stall); end
            ifu_req_fire = 1; step();
        end
        ifu_req_fire = 0;
        n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall got %0b exp 1", fetch_stall); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sat_busy got %0b exp 0", busy); end
        ifu_rsp_fire = 1; step(); ifu_rsp_fire = 0;
        n_checks++; if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL sat_release got %0b exp 0", fetch_stall); end
    endtask

    // entered with 3 fetches outstanding from the saturation test
    task automatic test_reset_mid();
        take_branch(64'h8000_0700);
        n_checks++; if (discard_rsp !== 1'b1) begin n_fail++; $display("FAIL rmid_drain got %0b exp 1", discard_rsp); end
        rst_n = 0; step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %0b exp 0", busy); end
        n_checks++; if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_stall got %0b exp 0", fetch_stall); end
        n_checks++; if (discard_rsp !== 1'b0) begin n_fail++; $display("FAIL rmid_discard got %0b exp 0", discard_rsp); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rmid_flush got %0b exp 0", flush); end
        n_checks++; if (ifu_redirect_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_vld got %0b exp 0", ifu_redirect_vld); end
        rst_n = 1; step();
        take_branch(64'h8000_0800);
        n_checks++; if (ifu_redirect_vld !== 1'b1) begin n_fail++; $display("FAIL rmid_cnt_clear got %0b exp 1", ifu_redirect_vld); end
        n_checks++; if (ifu_redirect_pc !== 64'h8000_0800) begin n_fail++; $display("FAIL rmid_pc got %h exp 80000800", ifu_redirect_pc); end
        ifu_redirect_rdy = 1; step(); clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_taken_direct();
        test_not_taken();
        test_drain();
        test_simultaneous();
        test_trap_override();
        test_trap_with_rdy();
        test_trap_in_drain();
        test_saturate_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
